rxparity: RTL and testbench

- USRT receive-side frame decoder; mirror of the transmit parity/framing path.
- Samples the serial line once per i_Pclk rising edge (one bit per clock, synchronous link).
- Detects the start bit, shifts in data LSB-first, optionally checks the parity bit and checks the stop bit.
- Presents the recovered byte with a one-cycle valid strobe and error flags to the host-side logic.

---
 rtl/rxparity_if.sv | 12 +
 rtl/rxparity.sv | 60 ++++++
 tb/tb_rxparity.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rxparity_if.sv
// rxparity_if: serial line, parity mode and decoded-frame signals of the USRT receiver.
interface rxparity_if #(parameter int DATA_BITS = 8);
  logic                 rx;
  logic [1:0]           parity;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;
  modport master (output rx, parity, input data, valid, parity_err, frame_err, busy);
  modport slave  (input rx, parity, output data, valid, parity_err, frame_err, busy);
endinterface

// File: rtl/rxparity.sv
// rxparity: synchronous serial frame decoder with optional odd/even parity and stop-bit check.
module rxparity #(
  parameter int DATA_BITS = 8
) (
  input logic      i_Pclk,
  input logic      i_Rst_n,
  rxparity_if.slave bus
);
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, BREAK} state_t;
  localparam int CW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  state_t               state, state_nx;
  logic [1:0]           mode;
  logic [DATA_BITS-1:0] sh;
  logic [CW-1:0]        cnt;
  logic                 pbit;
  logic                 last, par_en;
  assign last   = cnt == CW'(DATA_BITS - 1);
  assign par_en = mode == 2'b01 || mode == 2'b10;
  always_ff @(posedge i_Pclk or negedge i_Rst_n)
    if (!i_Rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.rx ? IDLE : DATA;
      DATA:    state_nx = !last ? DATA : par_en ? PARITY : STOP;
      PARITY:  state_nx = STOP;
      default: state_nx = bus.rx ? IDLE : BREAK;
    endcase
  end
  always_comb bus.busy = state != IDLE;
  // The mode is captured with the start bit so mid-frame changes are ignored.
  always_ff @(posedge i_Pclk or negedge i_Rst_n)
    if (!i_Rst_n) begin
      mode           <= '0;
      sh             <= '0;
      cnt            <= '0;
      pbit           <= 1'b0;
      bus.data       <= '0;
      bus.valid      <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      bus.valid <= state == STOP;
      if (state == IDLE && !bus.rx) begin
        mode <= bus.parity;
        cnt  <= '0;
      end
      if (state == DATA) begin
        sh  <= DATA_BITS'({bus.rx, sh} >> 1);
        cnt <= cnt + 1'b1;
      end
      if (state == PARITY) pbit <= bus.rx;
      if (state == STOP) begin
        bus.data       <= sh;
        bus.parity_err <= mode == 2'b01 ? ~(^{sh, pbit}) : mode == 2'b10 ? ^{sh, pbit} : 1'b0;
        bus.frame_err  <= ~bus.rx;
      end
    end
endmodule

// File: tb/tb_rxparity.sv
// tb_rxparity: randomized frame stimulus with a queued scoreboard checked by a valid-driven monitor.
module tb_rxparity;
  localparam int DB = 8;
  typedef struct {
    logic [DB-1:0] d;
    logic          pe;
    logic          fe;
    int            cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   pass = 0;
  int   total = 0;
  exp_t sb[$];
  rxparity_if #(.DATA_BITS(DB)) ifc ();
  rxparity #(.DATA_BITS(DB)) dut (.i_Pclk(clk), .i_Rst_n(rst_n), .bus(ifc));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a == e) pass++;
    else $display("FAIL %s: got %0d expected %0d", n, a, e);
  endtask
  task automatic bitx(input logic b, input logic [1:0] p);
    @(negedge clk);
    ifc.rx     = b;
    ifc.parity = p;
  endtask
  task automatic idle(input int n);
    repeat (n) bitx(1'b1, 2'($urandom_range(0, 3)));
  endtask
  // Reference: parity bit chosen so the data+parity ones count is odd (mode 01) or even (mode 10).
  task automatic send(input logic [DB-1:0] d, input logic [1:0] m, input bit bad, input bit stop);
    exp_t e;
    int   ones;
    logic pb;
    bit   pen;
    ones = $countones(d);
    pen  = m == 2'b01 || m == 2'b10;
    pb   = m == 2'b01 ? ((ones % 2) == 0) : ((ones % 2) == 1);
    if (bad) pb = ~pb;
    bitx(1'b0, m);
    for (int i = 0; i < DB; i++) bitx(d[i], 2'($urandom_range(0, 3)));
    if (pen) bitx(pb, 2'($urandom_range(0, 3)));
    bitx(stop, 2'($urandom_range(0, 3)));
    e.d   = d;
    e.pe  = pen && (((ones + int'(pb)) % 2) != (m == 2'b01 ? 1 : 0));
    e.fe  = !stop;
    e.cyc = cyc + 1;
    sb.push_back(e);
  endtask
  always @(negedge clk)
    if (ifc.valid) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_valid: got valid=1 expected no frame at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data", int'(ifc.data), int'(e.d));
        chk("parity_err", int'(ifc.parity_err), int'(e.pe));
        chk("frame_err", int'(ifc.frame_err), int'(e.fe));
        chk("valid_cycle", cyc, e.cyc);
      end
    end
  initial begin
    rst_n      = 1'b0;
    ifc.rx     = 1'b1;
    ifc.parity = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_data", int'(ifc.data), 0);
    chk("rst_valid", int'(ifc.valid), 0);
    chk("rst_perr", int'(ifc.parity_err), 0);
    chk("rst_ferr", int'(ifc.frame_err), 0);
    chk("rst_busy", int'(ifc.busy), 0);
    rst_n = 1'b1;
    idle(2);
    send(8'h03, 2'b01, 0, 1);
    idle(2);
    send(8'h07, 2'b10, 1, 1);
    idle(1);
    send(8'h07, 2'b10, 0, 1);
    idle(1);
    send(8'hA5, 2'b00, 0, 1);
    send(8'h3C, 2'b11, 0, 1);
    idle(1);
    send(8'h03, 2'b01, 0, 0);
    repeat (5) begin
      bitx(1'b0, 2'b00);
      chk("break_busy", int'(ifc.busy), 1);
    end
    bitx(1'b1, 2'b00);
    bitx(1'b1, 2'b00);
    chk("break_exit_busy", int'(ifc.busy), 0);
    send(8'h5A, 2'b01, 0, 1);
    idle(1);
    send(8'h03, 2'b10, 0, 1);
    send(8'h07, 2'b10, 0, 1);
    idle(2);
    bitx(1'b0, 2'b01);
    for (int i = 0; i < 4; i++) bitx(1'($urandom_range(0, 1)), 2'b01);
    #2 rst_n = 1'b0;
    ifc.rx = 1'b1;
    #1;
    chk("midrst_busy", int'(ifc.busy), 0);
    chk("midrst_data", int'(ifc.data), 0);
    chk("midrst_valid", int'(ifc.valid), 0);
    chk("midrst_perr", int'(ifc.parity_err), 0);
    chk("midrst_ferr", int'(ifc.frame_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send(8'h07, 2'b10, 0, 1);
    for (int n = 0; n < 40; n++) begin
      logic [DB-1:0] d;
      bit            stop;
      d    = DB'($urandom);
      stop = ($urandom % 5) != 0;
      send(d, 2'($urandom_range(0, 3)), ($urandom % 4) == 0, stop);
      if (!stop) begin
        repeat ($urandom_range(0, 3)) bitx(1'b0, 2'($urandom_range(0, 3)));
        bitx(1'b1, 2'($urandom_range(0, 3)));
      end
      idle($urandom_range(0, 2));
    end
    idle(5);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
